// File: rtl/iq_sample_fifo_pkg.sv
// Shared definitions for the I/Q sample FIFO.
//   - Parameter defaults: IQ_W, ADDR_W, DROP_W.
//   - Output-stage state encoding.
//   - pack_iq(): builds the stored word. I goes in the upper half because the
//     packetizer sends the upper half first.
package iq_sample_fifo_pkg;

  localparam int IQ_W_DEF   = 16;
  localparam int ADDR_W_DEF = 10;
  localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;
  localparam int DROP_W_DEF = 16;

  // States of the output stage (output register in front of the RAM).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // nothing in the output register
    ST_FETCH = 2'd1,  // RAM read in flight
    ST_VALID = 2'd2   // output register holds the head word
  } out_state_t;

  // Packs one sample pair at the default width.
  // The top level concatenates {i, q} in the same order for other widths.
  function automatic logic [2*IQ_W_DEF-1:0] pack_iq(
    input logic [IQ_W_DEF-1:0] i,
    input logic [IQ_W_DEF-1:0] q
  );
    return {i, q};
  endfunction

endpackage

// File: rtl/iq_sample_fifo_sdp_ram.sv
// Simple dual-port RAM for the sample FIFO.
// It has one write port and one registered read port on the same clock.
// Both ports access the same memory array.
//   i_clk    clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address, sampled every edge
//   o_rdata  registered read data
// A read and a write to the same address on the same edge return the old
// contents. The caller handles that case.
module sdp_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/iq_sample_fifo.sv
// Elastic first-word-fall-through FIFO.
// It buffers packed {I,Q} samples between the DDC output and the Ethernet
// packetizer. The sample source cannot stall, so a sample that arrives while
// the FIFO is full is dropped and counted.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   in_valid        a new sample is present on in_i / in_q
//   in_i, in_q      sample pair, IQ_W bits each
//   rd_en           consumer request; a word pops when rd_en & rd_dr
//   rd_data         head word {I,Q}, registered
//   rd_dr           head word present, registered
//   level           words held, including the output register and any word
//                   in flight from the RAM
//   overflow        sticky drop flag
//   drop_count      saturating count of dropped samples
//   clr_stats       clears overflow and drop_count; wins over a coincident drop
module iq_sample_fifo
  import iq_sample_fifo_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int IQ_W   = IQ_W_DEF,
  parameter int DROP_W = DROP_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [IQ_W-1:0]     in_i,
  input  logic [IQ_W-1:0]     in_q,
  input  logic                rd_en,
  output logic [2*IQ_W-1:0]   rd_data,
  output logic                rd_dr,
  output logic [ADDR_W:0]     level,
  output logic                overflow,
  output logic [DROP_W-1:0]   drop_count,
  input  logic                clr_stats
);

  localparam int              DEPTH    = 2 ** ADDR_W;
  localparam int              WORD_W   = 2 * IQ_W;
  localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);

  out_state_t        r_state;
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_level;
  logic [WORD_W-1:0] r_out;
  logic              r_rd_dr;
  logic              r_overflow;
  logic [DROP_W-1:0] r_drop_count;
  logic              r_byp;
  logic [WORD_W-1:0] r_byp_data;

  logic              w_pop;
  logic              w_full;
  logic              w_push;
  logic              w_drop;
  logic              w_we;
  logic              w_ram_ne;
  logic              w_load;
  logic [ADDR_W-1:0] w_rptr_next;
  logic [WORD_W-1:0] w_wdata;
  logic [WORD_W-1:0] w_ram_q;
  logic [WORD_W-1:0] w_head;

  assign w_wdata = {in_i, in_q};

  assign w_pop  = rd_en & r_rd_dr;
  assign w_full = (r_level == LVL_FULL);
  // A pop on the same edge frees a slot, so a full FIFO still accepts the sample.
  assign w_push = in_valid & (~w_full | w_pop);
  assign w_drop = in_valid & w_full & ~w_pop;
  assign w_we   = w_push & ~rst;

  // Words still in the RAM that have not been moved into the output register.
  // The RAM never holds DEPTH words: the output stage only leaves EMPTY when
  // level is small. Pointer inequality is therefore an exact non-empty test.
  assign w_ram_ne = (r_wptr != r_rptr);

  // The output register takes a word from the RAM when a fetch completes, or
  // when the head is popped and another word is waiting. The second case is
  // the no-bubble reload.
  assign w_load = (r_state == ST_FETCH) |
                  ((r_state == ST_VALID) & w_pop & w_ram_ne);

  // The RAM is read every edge at the next read pointer.
  // Its output is then always the word at r_rptr, already prefetched.
  assign w_rptr_next = rst ? '0 : (w_load ? r_rptr + 1'b1 : r_rptr);

  // A write to the address being read on the same edge returns stale RAM data.
  // The bypass register substitutes the freshly written word.
  assign w_head = r_byp ? r_byp_data : w_ram_q;

  sdp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (WORD_W)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (r_wptr),
    .i_wdata (w_wdata),
    .i_raddr (w_rptr_next),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_EMPTY;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_level      <= '0;
      r_out        <= '0;
      r_rd_dr      <= 1'b0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
      r_byp        <= 1'b0;
      r_byp_data   <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      r_rptr <= w_rptr_next;

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase

      r_byp      <= w_we & (r_wptr == w_rptr_next);
      r_byp_data <= w_wdata;

      unique case (r_state)
        ST_EMPTY: begin
          if (w_ram_ne) begin
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          r_out   <= w_head;
          r_rd_dr <= 1'b1;
          r_state <= ST_VALID;
        end
        ST_VALID: begin
          if (w_pop) begin
            if (w_ram_ne) begin
              r_out <= w_head;
            end else begin
              r_rd_dr <= 1'b0;
              r_state <= ST_EMPTY;
            end
          end
        end
        default: begin
          r_rd_dr <= 1'b0;
          r_state <= ST_EMPTY;
        end
      endcase

      if (clr_stats) begin
        r_overflow   <= 1'b0;
        r_drop_count <= '0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != '1) begin
          r_drop_count <= r_drop_count + DROP_W'(1);
        end
      end
    end
  end

  assign rd_data    = r_out;
  assign rd_dr      = r_rd_dr;
  assign level      = r_level;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule
